fetch_queue_tx: RTL and testbench
=================================

Name: fetch_queue_tx

Overview:
- Small circular instruction queue at the transmit end of the valid/ready pipeline interface.
- Sits between the fetch unit (push side) and the decode-stage pipeline register (pop side). Its valid_out, data_out and ready_out connect directly to that register's valid_in, data_in and ready_in.
- Obeys all producer obligations of the protocol: once valid is raised it is held with stable data until the handshake. It absorbs fetch bursts while decode stalls and is flushed on mispredict.

Parameters:
- T, logic, packet type carried (bench uses logic [31:0]).
- DEPTH, 4, number of entries; any integer >= 2; need not be a power of two.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0); one clock; reset is asynchronous and active-low.
- mispredict  in  1  synchronous flush request from the branch unit.
- wr_valid  in  1  fetch has a packet.
- wr_ready  out  1  queue accepts a packet this cycle.
- wr_data  in  T  packet from fetch.
- valid_out  out  1  head packet available to decode.
- ready_out  in  1  downstream (decode register) accepts.
- data_out  out  T  head packet.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - storage array mem[DEPTH]; head and tail pointers, each $clog2(DEPTH) bits; occupancy counter.
  - All are registered; no other state.
- Reset (reset==0, asynchronous):
  - head=0, tail=0, count=0, valid_out=0, wr_ready=1.
  - mem contents are don't-care; data_out is don't-care while valid_out=0.
  - Release is synchronous to clk. Reset asserted mid-burst discards all entries immediately, without waiting for a clock edge.
- Output rules:
  - valid_out = (count != 0).
  - data_out = mem[head].
  - wr_ready = (count != DEPTH).
  - All three are driven from registers only; there is no combinational path from ready_out or wr_valid to any output.
- Push: on a clock edge with wr_valid && wr_ready && !mispredict, mem[tail] <= wr_data and tail advances.
- Pop: on a clock edge with valid_out && ready_out && !mispredict, head advances.
- Pointer advance: pointer+1, wrapping from DEPTH-1 to 0 explicitly.
- Count update: count +1 on push only, -1 on pop only, unchanged on push and pop together.
- Latency: a packet pushed into an empty queue appears on valid_out/data_out the cycle after the push edge. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Legal whenever count is in 1..DEPTH-1; count is unchanged and both pointers advance.
  - When full, wr_ready=0, so a pop in that cycle does not admit a push. The freed slot is visible the next cycle.
  - When empty, valid_out=0, so only the push takes effect.
- Protocol obligation:
  - While valid_out=1 and ready_out=0, data_out and valid_out hold exactly their values on the next cycle unless mispredict is asserted.
  - A bench assertion enforces this.
- Mispredict:
  - On the edge it is sampled high: head=0, tail=0, count=0; any push or pop that cycle is discarded.
  - The next cycle shows valid_out=0 and wr_ready=1.
  - valid_out may drop without a handshake only in this case.
  - Mispredict held high for several cycles keeps the queue empty.
- Wrap-around: pushes and pops crossing index DEPTH-1 to 0 preserve FIFO order, including when DEPTH is not a power of two (e.g. 3).
- Overflow/underflow cannot occur by construction. A push attempted while wr_ready=0 is ignored, and fetch holds it.

Test Plan:
- Reset and single packet: reset low for 2 cycles, then push 0xA0000001 into the empty queue → valid_out=1 and data_out=0xA0000001 exactly one cycle later, count=1; ready_out=1 pops it and count returns to 0.
- Fill and stall: ready_out=0, push 0x10,0x11,0x12,0x13 (DEPTH=4) → count=4, wr_ready=0, data_out held at 0x10 every cycle. A fifth push of 0x14 is ignored. Raising ready_out drains 0x10..0x13 in order.
- Full-queue pop with push offered: count=4 with ready_out=1 and wr_valid=1 carrying 0x20 → that cycle pops only (count=3). 0x20 is accepted the next cycle; later drain order ends ...,0x13,0x20.
- Streaming wrap: ready_out=1 and wr_valid=1 continuously for 10 packets 0x30..0x39, with count held at 1 → output sequence 0x30..0x39 with no gaps or duplicates, and pointers wrapping twice. Repeat with DEPTH=3.
- Mispredict mid-stream: count=3 with push and pop active, mispredict pulsed for one cycle → next cycle count=0, valid_out=0, wr_ready=1. The packet pushed in the flush cycle never appears; a new push of 0x40 emerges next.
- Async reset mid-operation: count=2, then reset driven low between clock edges → valid_out=0 and count=0 before the next rising edge. After release, the first push of 0x50 is output as the sole packet.

Source files
------------

// File: rtl/fetch_queue_tx_if.sv
// Bus between the fetch unit, the instruction queue and the decode register.
//
// Handshake rule for both the push pair (wr_valid/wr_ready) and the pop pair
// (valid_out/ready_out): a transfer happens on a rising clk edge where valid
// and ready are both 1. Once valid is raised it stays high, with stable data,
// until that edge. Ready may change freely and never depends combinationally
// on valid.
interface fetch_queue_tx_if #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          wr_valid;
  logic          wr_ready;
  T              wr_data;
  logic          valid_out;
  logic          ready_out;
  T              data_out;
  logic [CW-1:0] count;

  // Queue side.
  modport master (
    input  wr_valid, wr_data, ready_out,
    output wr_ready, valid_out, data_out, count
  );

  // Fetch/decode side.
  modport slave (
    output wr_valid, wr_data, ready_out,
    input  wr_ready, valid_out, data_out, count
  );
endinterface

// File: rtl/fetch_queue_tx.sv
// Circular instruction queue between fetch (push) and the decode pipeline
// register (pop). It absorbs fetch bursts while decode stalls and empties
// completely on a mispredict. Every output comes from registered state only,
// so neither ready_out nor wr_valid has a combinational path to an output.
module fetch_queue_tx #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mispredict,
  fetch_queue_tx_if.master q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occ;
  logic          push;
  logic          pop;

  // Advance a pointer, wrapping explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outputs are decoded from the registered occupancy and head pointer.
  assign q.valid_out = (occ != '0);
  assign q.wr_ready  = (occ != CW'(DEPTH));
  assign q.data_out  = mem[head];
  assign q.count     = occ;

  // A flush cancels any transfer offered in the same cycle.
  assign push = q.wr_valid  && q.wr_ready  && !mispredict;
  assign pop  = q.valid_out && q.ready_out && !mispredict;

  // Storage write; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= q.wr_data;
  end

  // Pointer and occupancy update, with asynchronous clear and synchronous flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (mispredict) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue_tx.sv
// Bench for fetch_queue_tx: a DEPTH=4 and a DEPTH=3 instance share one
// stimulus stream. A queue-level model predicts every output each cycle, and
// directed steps pin counts and packet order with literal values.
module tb_fetch_queue_tx;
  localparam int W = 32;

  logic         clk        = 1'b0;
  logic         reset      = 1'b1;
  logic         mispredict = 1'b0;
  logic         wr_valid   = 1'b0;
  logic         ready_out  = 1'b0;
  logic [W-1:0] wr_data    = '0;

  int n_pass  = 0;
  int n_total = 0;

  // clock / reset
  always #5 clk = ~clk;

  fetch_queue_tx_if #(.T(logic [W-1:0]), .DEPTH(4)) if4 ();
  fetch_queue_tx_if #(.T(logic [W-1:0]), .DEPTH(3)) if3 ();

  assign if4.wr_valid  = wr_valid;
  assign if4.wr_data   = wr_data;
  assign if4.ready_out = ready_out;
  assign if3.wr_valid  = wr_valid;
  assign if3.wr_data   = wr_data;
  assign if3.ready_out = ready_out;

  fetch_queue_tx #(.T(logic [W-1:0]), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .mispredict(mispredict), .q(if4.master)
  );
  fetch_queue_tx #(.T(logic [W-1:0]), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .mispredict(mispredict), .q(if3.master)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard: plain FIFO model per instance
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q3[$];

  always @(posedge clk or negedge reset) begin
    if (!reset || mispredict) begin
      exp_q.delete();
      exp_q3.delete();
    end else begin
      automatic bit psh4 = wr_valid && (exp_q.size() < 4);
      automatic bit pop4 = ready_out && (exp_q.size() != 0);
      automatic bit psh3 = wr_valid && (exp_q3.size() < 3);
      automatic bit pop3 = ready_out && (exp_q3.size() != 0);
      if (pop4) void'(exp_q.pop_front());
      if (psh4) exp_q.push_back(wr_data);
      if (pop3) void'(exp_q3.pop_front());
      if (psh3) exp_q3.push_back(wr_data);
    end
  end

  // Popped packets as actually delivered by each DUT.
  logic [W-1:0] log4[$];
  logic [W-1:0] log3[$];

  logic         rst_seen = 1'b0;
  logic         p_valid4 = 1'b0, p_valid3 = 1'b0, p_ready = 1'b0, p_misp = 1'b0;
  logic [W-1:0] p_data4  = '0,   p_data3  = '0;

  always @(negedge reset) rst_seen <= 1'b1;

  // compare process: outputs vs. model, protocol hold, delivery log
  always @(negedge clk) begin
    chk("valid4", {31'b0, if4.valid_out}, {31'b0, exp_q.size() != 0});
    chk("wr_ready4", {31'b0, if4.wr_ready}, {31'b0, exp_q.size() != 4});
    chk("count4", W'(if4.count), W'(exp_q.size()));
    if (exp_q.size() != 0) chk("data4", if4.data_out, exp_q[0]);
    chk("valid3", {31'b0, if3.valid_out}, {31'b0, exp_q3.size() != 0});
    chk("wr_ready3", {31'b0, if3.wr_ready}, {31'b0, exp_q3.size() != 3});
    chk("count3", W'(if3.count), W'(exp_q3.size()));
    if (exp_q3.size() != 0) chk("data3", if3.data_out, exp_q3[0]);

    if (reset && !rst_seen && !p_ready && !p_misp) begin
      if (p_valid4) begin
        chk("hold_valid4", {31'b0, if4.valid_out}, 32'd1);
        chk("hold_data4", if4.data_out, p_data4);
      end
      if (p_valid3) begin
        chk("hold_valid3", {31'b0, if3.valid_out}, 32'd1);
        chk("hold_data3", if3.data_out, p_data3);
      end
    end

    if (reset && ready_out && !mispredict) begin
      if (if4.valid_out) log4.push_back(if4.data_out);
      if (if3.valid_out) log3.push_back(if3.data_out);
    end

    p_valid4 = if4.valid_out && reset;
    p_valid3 = if3.valid_out && reset;
    p_data4  = if4.data_out;
    p_data3  = if3.data_out;
    p_ready  = ready_out;
    p_misp   = mispredict;
    rst_seen = 1'b0;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [W-1:0] wd, input logic ro, input logic mp);
    wr_valid   = wv;
    wr_data    = wd;
    ready_out  = ro;
    mispredict = mp;
  endtask

  task automatic clear_logs();
    log4.delete();
    log3.delete();
  endtask

  initial begin
    logic [W-1:0] e4[$];
    logic [W-1:0] e3[$];

    #1 reset = 1'b0;
    step();
    step();
    chk("rst_valid", {31'b0, if4.valid_out}, 32'd0);
    chk("rst_wr_ready", {31'b0, if4.wr_ready}, 32'd1);
    chk("rst_count", W'(if4.count), 32'd0);
    reset = 1'b1;

    // single packet, one-cycle latency
    drive(1'b1, 32'hA000_0001, 1'b0, 1'b0);
    chk("no_bypass", {31'b0, if4.valid_out}, 32'd0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("single_valid", {31'b0, if4.valid_out}, 32'd1);
    chk("single_data", if4.data_out, 32'hA000_0001);
    chk("single_count", W'(if4.count), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("single_pop_count", W'(if4.count), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    clear_logs();

    // fill and stall
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + W'(i), 1'b0, 1'b0);
      step();
    end
    chk("fill_count4", W'(if4.count), 32'd4);
    chk("fill_wr_ready4", {31'b0, if4.wr_ready}, 32'd0);
    chk("fill_data4", if4.data_out, 32'h10);
    chk("fill_count3", W'(if3.count), 32'd3);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    step();
    step();
    chk("overflow_count4", W'(if4.count), 32'd4);
    chk("overflow_data4", if4.data_out, 32'h10);

    // full-queue pop with a push offered
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    step();
    chk("full_pop_count4", W'(if4.count), 32'd3);
    step();
    chk("accept_count4", W'(if4.count), 32'd3);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) step();
    chk("drain_count4", W'(if4.count), 32'd0);
    chk("drain_count3", W'(if3.count), 32'd0);
    e4 = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20};
    e3 = '{32'h10, 32'h11, 32'h12, 32'h20};
    chk("drain_len4", W'(log4.size()), W'(e4.size()));
    for (int i = 0; i < e4.size() && i < log4.size(); i++) chk("drain_order4", log4[i], e4[i]);
    chk("drain_len3", W'(log3.size()), W'(e3.size()));
    for (int i = 0; i < e3.size() && i < log3.size(); i++) chk("drain_order3", log3[i], e3[i]);
    drive(1'b0, '0, 1'b0, 1'b0);
    clear_logs();

    // streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h30 + W'(i), 1'b1, 1'b0);
      step();
      chk("stream_count4", W'(if4.count), 32'd1);
      chk("stream_count3", W'(if3.count), 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("stream_end_count4", W'(if4.count), 32'd0);
    chk("stream_len4", W'(log4.size()), 32'd10);
    chk("stream_len3", W'(log3.size()), 32'd10);
    for (int i = 0; i < 10 && i < log4.size(); i++) chk("stream_order4", log4[i], 32'h30 + W'(i));
    for (int i = 0; i < 10 && i < log3.size(); i++) chk("stream_order3", log3[i], 32'h30 + W'(i));
    drive(1'b0, '0, 1'b0, 1'b0);
    clear_logs();

    // mispredict mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h60 + W'(i), 1'b0, 1'b0);
      step();
    end
    chk("pre_flush_count4", W'(if4.count), 32'd3);
    drive(1'b1, 32'h63, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count4", W'(if4.count), 32'd0);
    chk("flush_valid4", {31'b0, if4.valid_out}, 32'd0);
    chk("flush_wr_ready4", {31'b0, if4.wr_ready}, 32'd1);
    chk("flush_count3", W'(if3.count), 32'd0);
    drive(1'b1, 32'h64, 1'b1, 1'b1);
    repeat (3) step();
    chk("held_flush_count4", W'(if4.count), 32'd0);
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    chk("post_flush_len4", W'(log4.size()), 32'd1);
    if (log4.size() != 0) chk("post_flush_data4", log4[0], 32'h40);
    chk("post_flush_len3", W'(log3.size()), 32'd1);
    if (log3.size() != 0) chk("post_flush_data3", log3[0], 32'h40);
    drive(1'b0, '0, 1'b0, 1'b0);
    clear_logs();

    // asynchronous reset mid-operation
    drive(1'b1, 32'h70, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h71, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_count4", W'(if4.count), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async_valid4", {31'b0, if4.valid_out}, 32'd0);
    chk("async_count4", W'(if4.count), 32'd0);
    chk("async_wr_ready4", {31'b0, if4.wr_ready}, 32'd1);
    chk("async_valid3", {31'b0, if3.valid_out}, 32'd0);
    chk("async_count3", W'(if3.count), 32'd0);
    step();
    reset = 1'b1;
    drive(1'b1, 32'h50, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    chk("post_rst_len4", W'(log4.size()), 32'd1);
    if (log4.size() != 0) chk("post_rst_data4", log4[0], 32'h50);
    chk("post_rst_len3", W'(log3.size()), 32'd1);
    if (log3.size() != 0) chk("post_rst_data3", log3[0], 32'h50);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
